// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the max-pooling tree.
//   clog2   : ceiling log2, used to size the tree depth and the beat counter.
//   lane_t  : signed container wide enough for any supported lane width.
//             Callers sign-extend their DATA_W lanes into it and slice the
//             result back, so one max function serves every lane width.
//   smax    : signed maximum shared by the tree stages and the accumulator.
// ---------------------------------------------------------------------------
package pool_pkg;

    localparam int LANE_MAX_W = 64;

    typedef logic signed [LANE_MAX_W-1:0] lane_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // On a tie both operands are identical, so which one is returned
    // does not matter.
    function automatic lane_t smax(input lane_t a, input lane_t b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_tree_if.sv
// ---------------------------------------------------------------------------
// max_pool_tree_if
// Beat input / pooled output bundle of max_pool_tree.
//   in_valid  : in_data holds a beat this cycle
//   in_data   : NUM_IN lanes, lane i at [i*DATA_W +: DATA_W]
//   clear     : abort the current window and flush the pipeline
//   out_valid : single-cycle pulse marking a pooled result
//   out_data  : pooled maximum, held between pulses
// Modports: master = producer/consumer side, slave = the pooling block.
// ---------------------------------------------------------------------------
interface max_pool_tree_if #(
    parameter int DATA_W = 18,
    parameter int NUM_IN = 4
) ();

    logic                     in_valid;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     clear;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output clear,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  clear,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pool_cmp_stage.sv
// ---------------------------------------------------------------------------
// pool_cmp_stage
// One level of the comparator tree: N signed lanes in, N/2 registered
// pairwise maxima out (element i = max(in[2i], in[2i+1])).
//   clk, rst_n : clock, synchronous active-low reset (clears the valid bit)
//   clear      : drops the valid bit next cycle
//   in_vld     : in_data carries a beat
//   in_data    : N lanes of DATA_W bits
//   out_vld    : out_data carries a reduced beat
//   out_data   : N/2 lanes of DATA_W bits
// Only the valid bit is reset; the data register simply follows its input.
// ---------------------------------------------------------------------------
module pool_cmp_stage
    import pool_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int N      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_vld,
    input  logic [N*DATA_W-1:0]        in_data,
    output logic                       out_vld,
    output logic [(N/2)*DATA_W-1:0]    out_data
);

    localparam int M = N / 2;

    logic [M*DATA_W-1:0] max_c;
    logic [M*DATA_W-1:0] max_p0;
    logic                vld_p0;

    function automatic logic signed [DATA_W-1:0] pair_max(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        lane_t w;
        w = smax(lane_t'(a), lane_t'(b));
        return w[DATA_W-1:0];
    endfunction

    always_comb begin
        max_c = '0;
        for (int i = 0; i < M; i++) begin
            max_c[i*DATA_W +: DATA_W] = pair_max(in_data[(2*i)*DATA_W +: DATA_W],
                                                 in_data[(2*i+1)*DATA_W +: DATA_W]);
        end
    end

    // ---- stage register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_vld && !clear;
        end
    end

    always_ff @(posedge clk) begin
        max_p0 <= max_c;
    end

    assign out_vld  = vld_p0;
    assign out_data = max_p0;

endmodule

// File: rtl/max_pool_tree.sv
// ---------------------------------------------------------------------------
// max_pool_tree
// Pipelined max-pooling unit. Each accepted beat of NUM_IN signed lanes is
// reduced to one maximum by log2(NUM_IN) registered comparator levels; an
// accumulator then folds BEATS consecutive tree results into one pooled
// value. Latency from the final beat to the out_valid pulse is
// log2(NUM_IN)+1 cycles. No backpressure.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (valids, counter, acc, out_data)
//   bus   : max_pool_tree_if.slave (in_valid, in_data, clear,
//           out_valid, out_data)
// Build option: define RELU_CLAMP_EN to write a negative pooled maximum as 0
// (fused ReLU). Internal compares stay signed either way.
// ---------------------------------------------------------------------------
module max_pool_tree
    import pool_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int NUM_IN = 4,
    parameter int BEATS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    max_pool_tree_if.slave  bus
);

    localparam int LOG2N = clog2(NUM_IN);
    localparam int CNT_W = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    function automatic logic signed [DATA_W-1:0] lane_max(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        lane_t w;
        w = smax(lane_t'(a), lane_t'(b));
        return w[DATA_W-1:0];
    endfunction

    // Output-side clamp; only the written value is clamped, never the
    // running accumulator.
    function automatic logic signed [DATA_W-1:0] relu_clamp(
        input logic signed [DATA_W-1:0] v
    );
`ifdef RELU_CLAMP_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // ---- comparator tree: level k halves NUM_IN>>k lanes ----
    for (genvar k = 0; k < LOG2N; k++) begin : g_lvl
        localparam int NK = NUM_IN >> k;

        logic [NK*DATA_W-1:0]     din;
        logic                     vin;
        logic [(NK/2)*DATA_W-1:0] dout;
        logic                     vout;

        if (k == 0) begin : g_first
            assign din = bus.in_data;
            assign vin = bus.in_valid;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
        end

        pool_cmp_stage #(
            .DATA_W (DATA_W),
            .N      (NK)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (bus.clear),
            .in_vld   (vin),
            .in_data  (din),
            .out_vld  (vout),
            .out_data (dout)
        );
    end

    logic signed [DATA_W-1:0] tree_max;
    logic                     tree_vld;

    assign tree_max = g_lvl[LOG2N-1].dout;
    assign tree_vld = g_lvl[LOG2N-1].vout;

    // ---- window accumulator / output register ----
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] acc;
    logic                     last_beat;

    // With BEATS==1 every tree result closes a window on its own.
    assign last_beat = (BEATS == 1) || (cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (bus.clear) begin
            // A final result colliding with clear is dropped; out_data holds.
            cnt           <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (tree_vld) begin
                if (last_beat) begin
                    bus.out_data  <= relu_clamp((BEATS == 1) ? tree_max
                                                             : lane_max(acc, tree_max));
                    bus.out_valid <= 1'b1;
                    cnt           <= '0;
                end else if (cnt == '0) begin
                    acc <= tree_max;
                    cnt <= CNT_W'(1);
                end else begin
                    acc <= lane_max(acc, tree_max);
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_tree.sv
// ---------------------------------------------------------------------------
// tb_max_pool_tree
// Directed bench for max_pool_tree. Three instances share clock and reset:
//   dut_a : DATA_W=18, NUM_IN=4, BEATS=1
//   dut_b : DATA_W=18, NUM_IN=4, BEATS=2
//   dut_c : DATA_W=16, NUM_IN=8, BEATS=1
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_max_pool_tree;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    max_pool_tree_if #(.DATA_W(18), .NUM_IN(4)) if_a ();
    max_pool_tree_if #(.DATA_W(18), .NUM_IN(4)) if_b ();
    max_pool_tree_if #(.DATA_W(16), .NUM_IN(8)) if_c ();

    max_pool_tree #(.DATA_W(18), .NUM_IN(4), .BEATS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    max_pool_tree #(.DATA_W(18), .NUM_IN(4), .BEATS(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    max_pool_tree #(.DATA_W(16), .NUM_IN(8), .BEATS(1)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [17:0] l0;
        logic signed [17:0] l1;
        logic signed [17:0] l2;
        logic signed [17:0] l3;
        logic signed [17:0] ex;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int a, input int b, input int c,
                                input int d, input int e);
        vec_t v;
        v.l0 = 18'(a);
        v.l1 = 18'(b);
        v.l2 = 18'(c);
        v.l3 = 18'(d);
        v.ex = 18'(e);
        return v;
    endfunction

    // Expected value as written to out_data.
    function automatic int rexp(input int x);
`ifdef RELU_CLAMP_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        if_a.in_valid = 1'b0; if_a.clear = 1'b0;
        if_b.in_valid = 1'b0; if_b.clear = 1'b0;
        if_c.in_valid = 1'b0; if_c.clear = 1'b0;
    endtask

    task automatic drive_a(input int a, input int b, input int c, input int d);
        if_a.in_data  = {18'(d), 18'(c), 18'(b), 18'(a)};
        if_a.in_valid = 1'b1;
    endtask

    task automatic drive_b(input int a, input int b, input int c, input int d);
        if_b.in_data  = {18'(d), 18'(c), 18'(b), 18'(a)};
        if_b.in_valid = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        if_a.in_data = '0;
        if_b.in_data = '0;
        if_c.in_data = '0;
        idle_all();

        vecs[0] = mk(5, -3, 17, 2, 17);
        vecs[1] = mk(0, 1, 0, -1, 1);
        vecs[2] = mk(-5, -3, -17, -2, -2);
        vecs[3] = mk(131071, -131072, 0, 0, 131071);
        vecs[4] = mk(-131072, -131072, -131072, -131072, -131072);
        vecs[5] = mk(3, 3, 3, 3, 3);
        vecs[6] = mk(-1, 0, -1, -1, 0);

        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state.
        check("rst_a_valid", int'(if_a.out_valid), 0);
        check("rst_a_data",  int'(if_a.out_data),  0);
        check("rst_b_valid", int'(if_b.out_valid), 0);
        check("rst_c_data",  int'(if_c.out_data),  0);

        // Table: single beats through the BEATS=1 instance, latency 3.
        for (int i = 0; i < 7; i++) begin
            drive_a(int'(vecs[i].l0), int'(vecs[i].l1), int'(vecs[i].l2), int'(vecs[i].l3));
            tick();
            if_a.in_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_early", i), int'(if_a.out_valid), 0);
            tick();
            check($sformatf("vec%0d_pulse", i), int'(if_a.out_valid), 1);
            check($sformatf("vec%0d_data", i),  int'(if_a.out_data),  rexp(int'(vecs[i].ex)));
            tick();
            check($sformatf("vec%0d_after", i), int'(if_a.out_valid), 0);
            check($sformatf("vec%0d_hold", i),  int'(if_a.out_data),  rexp(int'(vecs[i].ex)));
        end

        // Back-to-back beats: results on consecutive cycles.
        drive_a(5, -3, 17, 2);
        tick();
        drive_a(0, 1, 0, -1);
        tick();
        if_a.in_valid = 1'b0;
        tick();
        check("b2b_first_valid", int'(if_a.out_valid), 1);
        check("b2b_first_data",  int'(if_a.out_data),  17);
        tick();
        check("b2b_second_valid", int'(if_a.out_valid), 1);
        check("b2b_second_data",  int'(if_a.out_data),  1);
        tick();
        check("b2b_end_valid", int'(if_a.out_valid), 0);
        check("b2b_end_hold",  int'(if_a.out_data),  1);

        // Clear as a result reaches the accumulator, with a beat presented
        // alongside the clear: neither may produce a pulse.
        drive_a(9, 1, 1, 1);
        tick();
        if_a.in_valid = 1'b0;
        tick();
        drive_a(50, 0, 0, 0);
        if_a.clear = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        if_a.clear    = 1'b0;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("clr_a_nopulse%0d", t), int'(if_a.out_valid), 0);
            check($sformatf("clr_a_hold%0d", t),    int'(if_a.out_data),  1);
            tick();
        end

        // Reset while a beat is inside the tree.
        drive_a(10, 0, 0, 0);
        tick();
        if_a.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("rst_mid_nopulse%0d", t), int'(if_a.out_valid), 0);
            check($sformatf("rst_mid_data%0d", t),    int'(if_a.out_data),  0);
            tick();
        end

        // BEATS=2 with two idle cycles between the beats.
        drive_b(1, 2, 3, 4);
        tick();
        if_b.in_valid = 1'b0;
        tick();
        check("gap_nopulse0", int'(if_b.out_valid), 0);
        tick();
        check("gap_nopulse1", int'(if_b.out_valid), 0);
        drive_b(9, 0, 0, 0);
        tick();
        if_b.in_valid = 1'b0;
        check("gap_nopulse2", int'(if_b.out_valid), 0);
        tick();
        check("gap_nopulse3", int'(if_b.out_valid), 0);
        tick();
        check("gap_pulse",   int'(if_b.out_valid), 1);
        check("gap_data",    int'(if_b.out_data),  9);
        tick();
        check("gap_after",   int'(if_b.out_valid), 0);

        // BEATS=2: a half window discarded by clear.
        drive_b(7, 7, 7, 7);
        tick();
        if_b.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("clr_b_nopulse_a", int'(if_b.out_valid), 0);
        if_b.clear = 1'b1;
        tick();
        if_b.clear = 1'b0;
        drive_b(1, 0, 0, 0);
        tick();
        drive_b(2, 0, 0, 0);
        tick();
        if_b.in_valid = 1'b0;
        tick();
        check("clr_b_nopulse_b", int'(if_b.out_valid), 0);
        tick();
        check("clr_b_pulse", int'(if_b.out_valid), 1);
        check("clr_b_data",  int'(if_b.out_data),  2);
        tick();
        check("clr_b_after", int'(if_b.out_valid), 0);

        // BEATS=2, negative window, back-to-back beats.
        drive_b(-8, -9, -10, -11);
        tick();
        drive_b(-20, -30, -40, -50);
        tick();
        if_b.in_valid = 1'b0;
        tick();
        check("neg_b_nopulse", int'(if_b.out_valid), 0);
        tick();
        check("neg_b_pulse", int'(if_b.out_valid), 1);
        check("neg_b_data",  int'(if_b.out_data),  rexp(-8));
        tick();

        // NUM_IN=8, DATA_W=16: latency 4.
        if_c.in_data  = {16'h7FFF, 16'h8000, 16'h8000, 16'h8000,
                         16'h8000, 16'h8000, 16'h8000, 16'h8000};
        if_c.in_valid = 1'b1;
        tick();
        if_c.in_valid = 1'b0;
        tick();
        tick();
        check("c8_early", int'(if_c.out_valid), 0);
        tick();
        check("c8_pulse", int'(if_c.out_valid), 1);
        check("c8_data",  int'(if_c.out_data),  32767);

        if_c.in_data  = {16'h8000, 16'h8000, 16'h8000, 16'h8000,
                         16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
        if_c.in_valid = 1'b1;
        tick();
        if_c.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("c8_neg_pulse", int'(if_c.out_valid), 1);
        check("c8_neg_data",  int'(if_c.out_data),  rexp(-1));

        if_c.in_data  = {16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C,
                         16'h0064, 16'hFF9C, 16'hFF9C, 16'hFF9C};
        if_c.in_valid = 1'b1;
        tick();
        if_c.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("c8_mid_pulse", int'(if_c.out_valid), 1);
        check("c8_mid_data",  int'(if_c.out_data),  100);
        tick();
        check("c8_mid_after", int'(if_c.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
